// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one purely combinational ALU among NUM_REQ requesters. A grant is
//   issued whenever the single-entry response register is empty or is being
//   drained in the same cycle. The winner's func/operands are driven to the
//   ALU, and its result is captured together with the winner's index.
//
// Ports
//   clk_i         clock, rising edge
//   reset_i       synchronous reset, active low
//   req_valid_i   per-requester request valid
//   req_ready_o   per-requester accept (one-hot or zero)
//   req_func_i    packed 4-bit func codes, requester k at [4k+3:4k]
//   req_src1_i    packed 32-bit operand 1, requester k at [32k+31:32k]
//   req_src2_i    packed 32-bit operand 2, same packing
//   alu_func_o    func to the shared ALU
//   alu_src1_o    operand 1 to the shared ALU
//   alu_src2_o    operand 2 to the shared ALU
//   alu_result_i  combinational result returned by the shared ALU
//   rsp_valid_o   response register holds a result
//   rsp_ready_i   consumer accepts the response
//   rsp_data_o    captured ALU result
//   rsp_id_o      index of the requester that produced rsp_data_o
module alu_share_arbiter #(
    parameter int NUM_REQ  = 2,
    parameter int ARB_MODE = 0,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [NUM_REQ-1:0]      req_valid_i,
    output logic [NUM_REQ-1:0]      req_ready_o,
    input  logic [4*NUM_REQ-1:0]    req_func_i,
    input  logic [32*NUM_REQ-1:0]   req_src1_i,
    input  logic [32*NUM_REQ-1:0]   req_src2_i,
    output logic [3:0]              alu_func_o,
    output logic [31:0]             alu_src1_o,
    output logic [31:0]             alu_src2_o,
    input  logic [31:0]             alu_result_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [31:0]             rsp_data_o,
    output logic [IDW-1:0]          rsp_id_o
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]     state;
    logic [IDW-1:0] rr_ptr;
    logic [31:0]    rsp_data_p1;
    logic [IDW-1:0] rsp_id_p1;

    logic           can_issue;
    logic           grant_any;
    logic [IDW-1:0] grant_idx;
    logic [IDW-1:0] sel_idx;
    logic           transfer;

    // Increment an index modulo NUM_REQ (NUM_REQ need not be a power of two).
    function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] idx);
        if (idx == IDW'(NUM_REQ - 1))
            wrap_inc = '0;
        else
            wrap_inc = idx + IDW'(1);
    endfunction

    // Issue is blocked during reset so nothing is accepted that would be dropped.
    assign can_issue = reset_i && ((state == ST_EMPTY) || rsp_ready_i);

    // Scan offsets from highest to lowest so the smallest offset from the
    // search base wins. The base is the RR pointer in round-robin mode, 0 otherwise.
    always_comb begin
        int cand;
        int base;
        cand      = 0;
        base      = (ARB_MODE == 0) ? int'(rr_ptr) : 0;
        grant_any = 1'b0;
        grant_idx = '0;
        if (can_issue) begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                cand = base + k;
                if (cand >= NUM_REQ)
                    cand = cand - NUM_REQ;
                if (req_valid_i[cand]) begin
                    grant_any = 1'b1;
                    grant_idx = IDW'(cand);
                end
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        for (int k = 0; k < NUM_REQ; k++)
            req_ready_o[k] = grant_any && (grant_idx == IDW'(k));
    end

    // With no grant the ALU sees requester 0, a stable don't-care value.
    assign sel_idx    = grant_any ? grant_idx : '0;
    assign alu_func_o = req_func_i[int'(sel_idx)*4 +: 4];
    assign alu_src1_o = req_src1_i[int'(sel_idx)*32 +: 32];
    assign alu_src2_o = req_src2_i[int'(sel_idx)*32 +: 32];

    assign transfer = |(req_valid_i & req_ready_o);

    // Stage p1: response register, written on transfer, cleared on drain.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state       <= ST_EMPTY;
            rsp_data_p1 <= '0;
            rsp_id_p1   <= '0;
            rr_ptr      <= '0;
        end else if (transfer) begin
            state       <= ST_FULL;
            rsp_data_p1 <= alu_result_i;
            rsp_id_p1   <= grant_idx;
            if (ARB_MODE == 0)
                rr_ptr <= wrap_inc(grant_idx);
        end else if ((state == ST_FULL) && rsp_ready_i) begin
            state <= ST_EMPTY;
        end
    end

    assign rsp_valid_o = (state == ST_FULL);
    assign rsp_data_o  = rsp_data_p1;
    assign rsp_id_o    = rsp_id_p1;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter: a round-robin and a fixed-priority instance
// share the same request stimulus; each has its own ALU model. A cycle-level
// reference model predicts grants, ALU drive and the response register.
module tb_alu_share_arbiter;

    localparam int N   = 3;
    localparam int IDW = $clog2(N);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic [N-1:0]      req_valid;
    logic [4*N-1:0]    req_func;
    logic [32*N-1:0]   req_src1;
    logic [32*N-1:0]   req_src2;
    logic              rsp_ready;

    logic [N-1:0]      rr_ready,     fp_ready;
    logic [3:0]        rr_func,      fp_func;
    logic [31:0]       rr_src1,      fp_src1;
    logic [31:0]       rr_src2,      fp_src2;
    logic [31:0]       rr_result,    fp_result;
    logic              rr_rsp_valid, fp_rsp_valid;
    logic [31:0]       rr_rsp_data,  fp_rsp_data;
    logic [IDW-1:0]    rr_rsp_id,    fp_rsp_id;

    int tests = 0;
    int fails = 0;

    // Reference model state, index 0 = round-robin, 1 = fixed priority.
    bit          m_valid [2];
    logic [31:0] m_data  [2];
    int          m_id    [2];
    int          m_ptr   [2];

    function automatic logic [31:0] alu_ref(input logic [3:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
        case (f)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a ^ b;
            4'd3:    return a & b;
            4'd4:    return a | b;
            4'd5:    return a << b[4:0];
            default: return a;
        endcase
    endfunction

    assign rr_result = alu_ref(rr_func, rr_src1, rr_src2);
    assign fp_result = alu_ref(fp_func, fp_src1, fp_src2);

    alu_share_arbiter #(.NUM_REQ(N), .ARB_MODE(0)) u_rr (
        .clk_i(clk), .reset_i(reset),
        .req_valid_i(req_valid), .req_ready_o(rr_ready),
        .req_func_i(req_func), .req_src1_i(req_src1), .req_src2_i(req_src2),
        .alu_func_o(rr_func), .alu_src1_o(rr_src1), .alu_src2_o(rr_src2),
        .alu_result_i(rr_result),
        .rsp_valid_o(rr_rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_data_o(rr_rsp_data), .rsp_id_o(rr_rsp_id)
    );

    alu_share_arbiter #(.NUM_REQ(N), .ARB_MODE(1)) u_fp (
        .clk_i(clk), .reset_i(reset),
        .req_valid_i(req_valid), .req_ready_o(fp_ready),
        .req_func_i(req_func), .req_src1_i(req_src1), .req_src2_i(req_src2),
        .alu_func_o(fp_func), .alu_src1_o(fp_src1), .alu_src2_o(fp_src2),
        .alu_result_i(fp_result),
        .rsp_valid_o(fp_rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_data_o(fp_rsp_data), .rsp_id_o(fp_rsp_id)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s at %0t: observed %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic set_req(input int k, input logic [3:0] f, input logic [31:0] a,
                           input logic [31:0] b);
        req_func[4*k +: 4]  = f;
        req_src1[32*k +: 32] = a;
        req_src2[32*k +: 32] = b;
    endtask

    // Check all outputs against the model, clock once, advance the model.
    task automatic step();
        int          win [2];
        int          idx;
        int          sel;
        logic [N-1:0] er;
        string       nm;
        #1;
        for (int m = 0; m < 2; m++) begin
            nm = (m == 0) ? "rr" : "fp";
            win[m] = -1;
            if (reset && (!m_valid[m] || rsp_ready)) begin
                for (int k = 0; k < N; k++) begin
                    idx = (m == 0) ? ((m_ptr[m] + k) % N) : k;
                    if (win[m] < 0 && req_valid[idx])
                        win[m] = idx;
                end
            end
            er = '0;
            if (win[m] >= 0)
                er[win[m]] = 1'b1;
            sel = (win[m] >= 0) ? win[m] : 0;
            chk($sformatf("%s_ready", nm), 32'(m == 0 ? rr_ready : fp_ready), 32'(er));
            chk($sformatf("%s_alu_func", nm), 32'(m == 0 ? rr_func : fp_func),
                32'(req_func[4*sel +: 4]));
            chk($sformatf("%s_alu_src1", nm), m == 0 ? rr_src1 : fp_src1, req_src1[32*sel +: 32]);
            chk($sformatf("%s_alu_src2", nm), m == 0 ? rr_src2 : fp_src2, req_src2[32*sel +: 32]);
            chk($sformatf("%s_rsp_valid", nm), 32'(m == 0 ? rr_rsp_valid : fp_rsp_valid),
                32'(m_valid[m]));
            chk($sformatf("%s_rsp_data", nm), m == 0 ? rr_rsp_data : fp_rsp_data, m_data[m]);
            chk($sformatf("%s_rsp_id", nm), 32'(m == 0 ? rr_rsp_id : fp_rsp_id), 32'(m_id[m]));
        end
        @(posedge clk);
        for (int m = 0; m < 2; m++) begin
            if (!reset) begin
                m_valid[m] = 1'b0;
                m_data[m]  = '0;
                m_id[m]    = 0;
                m_ptr[m]   = 0;
            end else if (win[m] >= 0) begin
                m_valid[m] = 1'b1;
                m_data[m]  = alu_ref(req_func[4*win[m] +: 4], req_src1[32*win[m] +: 32],
                                     req_src2[32*win[m] +: 32]);
                m_id[m]    = win[m];
                if (m == 0)
                    m_ptr[m] = (win[m] + 1) % N;
            end else if (m_valid[m] && rsp_ready) begin
                m_valid[m] = 1'b0;
            end
        end
        #1;
    endtask

    initial begin
        // Reset held with all inputs active
        reset     = 1'b0;
        rsp_ready = 1'b1;
        req_valid = '1;
        for (int k = 0; k < N; k++)
            set_req(k, 4'(k), 32'(100 + k), 32'(k));
        @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            m_valid[m] = 1'b0; m_data[m] = '0; m_id[m] = 0; m_ptr[m] = 0;
        end
        step();
        chk("t1_rsp_valid", 32'(rr_rsp_valid), 32'd0);
        chk("t1_rsp_data", rr_rsp_data, 32'd0);

        // Single op on requester 0
        reset     = 1'b1;
        req_valid = 3'b001;
        set_req(0, 4'b0000, 32'd5, 32'd7);
        #1;
        chk("t2_ready", 32'(rr_ready), 32'd1);
        step();
        chk("t2_rsp_valid", 32'(rr_rsp_valid), 32'd1);
        chk("t2_rsp_data", rr_rsp_data, 32'd12);
        chk("t2_rsp_id", 32'(rr_rsp_id), 32'd0);
        req_valid = '0;
        step();

        // Round-robin alternation / fixed priority, from a fresh pointer
        reset = 1'b0;
        step();
        reset = 1'b1;
        set_req(0, 4'b0001, 32'd10, 32'd3);
        set_req(1, 4'b0010, 32'hF0, 32'h0F);
        req_valid = 3'b011;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t3_rr_id", 32'(rr_rsp_id), 32'(i % 2));
            chk("t3_rr_data", rr_rsp_data, (i % 2) ? 32'hFF : 32'd7);
            chk("t5_fp_id", 32'(fp_rsp_id), 32'd0);
        end
        req_valid = 3'b010;
        step();
        chk("t5_fp_id_after_drop", 32'(fp_rsp_id), 32'd1);
        chk("t5_fp_data_after_drop", fp_rsp_data, 32'hFF);

        // Backpressure
        req_valid = 3'b011;
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t4_ready_held", 32'(rr_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        step();
        chk("t4_regrant", 32'(rr_rsp_valid), 32'd1);

        // Reset while FULL
        reset = 1'b0;
        step();
        chk("t6_rsp_valid", 32'(rr_rsp_valid), 32'd0);
        reset = 1'b1;
        step();
        chk("t6_ptr_restart", 32'(rr_rsp_id), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            reset     = ($urandom_range(0, 49) != 0);
            rsp_ready = ($urandom_range(0, 9) < 7);
            req_valid = N'($urandom);
            for (int k = 0; k < N; k++)
                set_req(k, 4'($urandom_range(0, 6)), $urandom, $urandom);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
